// File: rtl/pulse_sync_sched_if.sv
// Handshake bundle between event sources and the pulse-crossing scheduler.
// The scheduler connects through the slave modport; the source side uses master.
interface pulse_sync_sched_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                en;
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  ovf_clr;
  logic [NUM_REQ-1:0]  ack;
  logic                sync_pulse;
  logic [ID_W-1:0]     sync_id;
  logic                busy;
  logic [NUM_REQ-1:0]  pend;
  logic [NUM_REQ-1:0]  ovf;

  modport master (
    output en, req, ovf_clr,
    input  ack, sync_pulse, sync_id, busy, pend, ovf
  );

  modport slave (
    input  en, req, ovf_clr,
    output ack, sync_pulse, sync_id, busy, pend, ovf
  );
endinterface

// File: rtl/pulse_sync_sched.sv
// Round-robin scheduler sharing one fast-to-slow pulse channel among NUM_REQ sources.
// Define PULSE_SYNC_SCHED_OVF_EN to implement the sticky coalesce (ovf) flags.
module pulse_sync_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned PULSE_LEN  = 2,
  parameter int unsigned GAP_CYCLES = 8
) (
  input logic               clk,
  input logic               rst,
  pulse_sync_sched_if.slave bus
);
  localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_MAX = (PULSE_LEN > GAP_CYCLES) ? PULSE_LEN : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {StIdle, StPulse, StGap} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    last_q, last_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_REQ-1:0] pend_q, pend_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic               pulse_q, pulse_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] grant_vec;
  logic [ID_W-1:0]    win;
  logic [ID_W-1:0]    idx;
  logic               found;

  // First pending source after the previous winner, wrapping around.
  always_comb begin
    win   = last_q;
    idx   = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      idx = ID_W'((32'(last_q) + off) % NUM_REQ);
      if (!found && pend_q[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    id_d      = id_q;
    grant_vec = '0;
    unique case (state_q)
      StIdle: begin
        if (bus.en && found) begin
          state_d        = StPulse;
          cnt_d          = CNT_W'(PULSE_LEN - 1);
          grant_vec[win] = 1'b1;
          last_d         = win;
          id_d           = win;
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = StGap;
          cnt_d   = CNT_W'(GAP_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StGap: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // A request on its own grant edge is a fresh event, so it re-arms pend.
  always_comb begin
    pend_d  = bus.req | (pend_q & ~grant_vec);
    ack_d   = grant_vec;
    pulse_d = (state_d == StPulse);
    busy_d  = (state_d != StIdle);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      pend_q  <= '0;
      ack_q   <= '0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
      ack_q   <= ack_d;
      pulse_q <= pulse_d;
      busy_q  <= busy_d;
    end
  end

`ifdef PULSE_SYNC_SCHED_OVF_EN
  logic [NUM_REQ-1:0] ovf_q, ovf_d, ovf_set;

  // Set wins over a same-edge clear.
  always_comb begin
    ovf_set = bus.req & pend_q & ~grant_vec;
    ovf_d   = (ovf_q & ~bus.ovf_clr) | ovf_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= '0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ^bus.ovf_clr;
  assign bus.ovf        = '0;
`endif

  assign bus.ack        = ack_q;
  assign bus.sync_pulse = pulse_q;
  assign bus.sync_id    = id_q;
  assign bus.busy       = busy_q;
  assign bus.pend       = pend_q;
endmodule

// File: tb/tb_pulse_sync_sched.sv
// Self-checking bench for pulse_sync_sched: directed scenarios plus randomized traffic
// checked every cycle against a grant-time based behavioural model.
module tb_pulse_sync_sched;
  localparam int N = 4;
  localparam int P = 2;
  localparam int G = 8;
`ifdef PULSE_SYNC_SCHED_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  pulse_sync_sched_if #(.NUM_REQ(N)) bus ();

  pulse_sync_sched #(
    .NUM_REQ   (N),
    .PULSE_LEN (P),
    .GAP_CYCLES(G)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model state: the channel is described only by the edge of the last grant.
  int         e = 0;
  int         m_g = 0;
  bit         m_have = 1'b0;
  int         m_last = N - 1;
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_ovf = '0;
  logic [N-1:0] exp_ack = '0;
  logic       exp_pulse = 1'b0;
  logic       exp_busy = 1'b0;
  logic [1:0] exp_id = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_have = 1'b0; m_last = N - 1; m_pend = '0; m_ovf = '0;
    exp_ack = '0; exp_pulse = 1'b0; exp_busy = 1'b0; exp_id = '0;
  endtask

  task automatic model_edge();
    int win;
    bit free;
    e++;
    free = !m_have || (e - m_g > P + G);
    win  = -1;
    if (free && bus.en && m_pend != '0) begin
      for (int off = 1; off <= N; off++) begin
        automatic int k = (m_last + off) % N;
        if (win < 0 && m_pend[k]) win = k;
      end
    end
`ifdef PULSE_SYNC_SCHED_OVF_EN
    for (int i = 0; i < N; i++) begin
      if (bus.ovf_clr[i]) m_ovf[i] = 1'b0;
      if (bus.req[i] && m_pend[i] && i != win) m_ovf[i] = 1'b1;
    end
`endif
    for (int i = 0; i < N; i++) m_pend[i] = bus.req[i] | (m_pend[i] & (i != win));
    if (win >= 0) begin
      m_have = 1'b1; m_g = e; m_last = win; exp_id = 2'(win);
    end
    exp_ack   = (m_have && e == m_g) ? N'(1 << m_last) : '0;
    exp_pulse = m_have && (e - m_g < P);
    exp_busy  = m_have && (e - m_g < P + G);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // Called at a falling edge; leaves time before the next rising edge.
  task automatic do_reset();
    #1 rst = 1'b1;
    #1 model_reset();
    #1 rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("ack", 32'(bus.ack), 32'(exp_ack));
      chk("sync_pulse", 32'(bus.sync_pulse), 32'(exp_pulse));
      chk("busy", 32'(bus.busy), 32'(exp_busy));
      chk("sync_id", 32'(bus.sync_id), 32'(exp_id));
      chk("pend", 32'(bus.pend), 32'(m_pend));
      chk("ovf", 32'(bus.ovf), 32'(m_ovf));
      chk("ack_onehot0", 32'($onehot0(bus.ack)), 32'd1);
    end
  end

  initial begin
    int npulse, nbusy, nack, gcnt, second;
    int ids[8];
    int edges[8];
    bus.en = 1'b1; bus.req = '0; bus.ovf_clr = '0;
    model_reset();
    @(negedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_pend", 32'(bus.pend), 32'd0);
    chk("rst_id", 32'(bus.sync_id), 32'd0);

    // Single event
    bus.req = 4'b0100; tick(); bus.req = '0;
    chk("single_pend", 32'(bus.pend), 32'b0100);
    chk("single_noack", 32'(bus.ack), 32'd0);
    tick();
    chk("single_ack", 32'(bus.ack), 32'b0100);
    chk("single_id", 32'(bus.sync_id), 32'd2);
    npulse = 0; nbusy = 0;
    for (int c = 0; c < 14; c++) begin
      npulse += int'(bus.sync_pulse); nbusy += int'(bus.busy); tick();
    end
    chk("single_pulse_len", 32'(npulse), 32'd2);
    chk("single_busy_len", 32'(nbusy), 32'd10);

    // Round-robin from reset
    do_reset();
    bus.req = 4'b1111; tick(); bus.req = '0;
    gcnt = 0;
    for (int c = 0; c < 60; c++) begin
      if (bus.ack != '0 && gcnt < 8) begin
        ids[gcnt] = int'(bus.sync_id); edges[gcnt] = c; gcnt++;
      end
      tick();
    end
    chk("rr_count", 32'(gcnt), 32'd4);
    for (int k = 0; k < 4; k++) chk("rr_order", 32'(ids[k]), 32'(k));
    for (int k = 1; k < 4; k++) chk("rr_period", 32'(edges[k] - edges[k-1]), 32'd11);
    chk("rr_no_ovf", 32'(bus.ovf), 32'd0);

    // Coalesce while source 0 holds the channel
    do_reset();
    bus.req = 4'b0001; tick(); bus.req = '0; tick();
    bus.req = 4'b0010; tick(); tick(); bus.req = '0;
    chk("coal_ovf", 32'(bus.ovf[1]), 32'(OVF_ON));
    nack = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus.ack[1]) nack++;
      tick();
    end
    chk("coal_one_grant", 32'(nack), 32'd1);
    bus.req = 4'b0001; tick(); bus.req = '0; tick();
    bus.req = 4'b0010; tick();
    bus.ovf_clr = 4'b0010; tick();
    bus.req = '0;
    chk("coal_set_wins", 32'(bus.ovf[1]), 32'(OVF_ON));
    tick(); bus.ovf_clr = '0;
    chk("ovf_cleared", 32'(bus.ovf[1]), 32'd0);
    repeat (30) tick();

    // Re-request on the grant edge
    do_reset();
    bus.req = 4'b1000; tick(); tick(); bus.req = '0;
    chk("rereq_ack", 32'(bus.ack), 32'b1000);
    chk("rereq_pend", 32'(bus.pend[3]), 32'd1);
    chk("rereq_ovf", 32'(bus.ovf[3]), 32'd0);
    second = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (second < 0 && bus.ack == 4'b1000) second = c;
    end
    chk("rereq_second", 32'(second), 32'd11);

    // Enable gating
    do_reset();
    bus.en = 1'b0; bus.req = 4'b0011; tick(); bus.req = '0;
    chk("en_pend", 32'(bus.pend), 32'b0011);
    nack = 0;
    for (int c = 0; c < 20; c++) begin
      tick(); if (bus.ack != '0) nack++;
    end
    chk("en_no_ack", 32'(nack), 32'd0);
    bus.en = 1'b1; tick();
    chk("en_grant0", 32'(bus.ack), 32'b0001);
    bus.en = 1'b0;
    npulse = 0; nbusy = 0;
    for (int c = 0; c < 14; c++) begin
      npulse += int'(bus.sync_pulse); nbusy += int'(bus.busy); tick();
    end
    chk("en_pulse_len", 32'(npulse), 32'd2);
    chk("en_busy_len", 32'(nbusy), 32'd10);
    bus.en = 1'b1;

    // Async reset mid-pulse
    do_reset();
    bus.req = 4'b0100; tick(); bus.req = 4'b0010; tick(); bus.req = '0;
    chk("ar_pulse_before", 32'(bus.sync_pulse), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("ar_pulse", 32'(bus.sync_pulse), 32'd0);
    chk("ar_busy", 32'(bus.busy), 32'd0);
    chk("ar_pend", 32'(bus.pend), 32'd0);
    model_reset();
    #1 rst = 1'b0;
    @(negedge clk);
    bus.req = 4'b0110; tick(); bus.req = '0; tick();
    chk("ar_first_ack", 32'(bus.ack), 32'b0010);
    chk("ar_first_id", 32'(bus.sync_id), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      bus.req     = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      bus.en      = ($urandom_range(0, 9) != 0);
      bus.ovf_clr = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pulse_sync_sched.md
# pulse_sync_sched

Fast-domain scheduler that shares one pulse-crossing channel (pulse synchronizer plus a held ID bus) between NUM_REQ event sources. It latches single-cycle event requests as pending bits and grants them round-robin. For each grant it emits one stretched pulse with the winner's ID, then enforces a guard gap so the slow-domain receiver sees every event exactly once. It sits in the HSSI exerciser control path, upstream of the fast-to-slow pulse synchronizer.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..16.
- PULSE_LEN, 2, cycles sync_pulse stays high per grant; must be ≥1.
- GAP_CYCLES, 8, idle cycles after each pulse before the next grant; must be ≥1. Size it to at least 3 slow-clock periods.
- ID_W, localparam, $clog2(NUM_REQ).
- clk  in  1  fast clock; all logic runs on it.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  grant enable. When low, no new grant starts; a pulse or gap already in progress completes.
- req  in  NUM_REQ  per-source event strobes; each set bit is one event.
- ack  out  NUM_REQ  one-cycle, one-hot grant strobe to the winning source.
- sync_pulse  out  1  to the synchronizer's fast_pulse input.
- sync_id  out  ID_W  winner index, stable from grant through end of gap.
- busy  out  1  high in the PULSE and GAP states.
- pend  out  NUM_REQ  pending-event bits.
- ovf  out  NUM_REQ  sticky coalesce flags (see Configuration).
- ovf_clr  in  NUM_REQ  clears the matching ovf bits.

## Operation
- Reset values: pend=0, ovf=0, ack=0, sync_pulse=0, sync_id=0, busy=0, state=IDLE, last_grant=NUM_REQ-1. With this last_grant value, req[0] has top priority first.
- Pending: at an edge where req[i]=1, pend[i] is set. It is cleared at the edge that grants i, unless req[i]=1 at that same edge, in which case pend[i] stays set (a new event, not an overflow).
- Coalesce: if req[i]=1 while pend[i]=1 and i is not granted at that edge, the events merge into one and ovf[i] sets.
- FSM states are IDLE, PULSE and GAP:
  - IDLE → PULSE when en=1 and pend≠0. The winner is the first set pend bit scanning from last_grant+1 upward, with wrap. On this edge: ack[winner]=1 for one cycle, sync_id=winner, last_grant=winner.
  - PULSE: sync_pulse=1 for exactly PULSE_LEN cycles, then → GAP.
  - GAP: sync_pulse=0 for exactly GAP_CYCLES cycles, then → IDLE.
- Width and counter rules: a single down-counter of width $clog2(max(PULSE_LEN,GAP_CYCLES)+1) is loaded on each state entry. sync_id is held until the next grant.
- en going low mid-PULSE or mid-GAP has no effect on the current sequence.
- Reset mid-operation: all state clears immediately and asynchronously; pending events are discarded.

## Timing
- req[i] sampled at edge k → pend[i]=1 after edge k. If IDLE and en=1, the grant happens at edge k+1: ack, sync_pulse and busy go high after edge k+1.
- Back-to-back grant period is 1 + PULSE_LEN + GAP_CYCLES edges. This is the IDLE cycle plus the pulse plus the gap; the IDLE cycle between grants is mandatory.
- ovf[i] sets at the edge where the coalesce occurs.
- ovf_clr[i] clears at its edge. If a coalesce happens at the same edge, set wins.
- No combinational path from any input to any output; all outputs are registered.

## Configuration
- PULSE_SYNC_SCHED_OVF_EN defined: the ovf logic is implemented as specified.
- Not defined:
  - ovf is tied to 0 and ovf_clr is ignored.
  - Coalescing still merges events silently.
  - All other behaviour is identical.

## Test plan
- Single event: req=4'b0100 for 1 cycle → pend[2] set. Next edge: ack=4'b0100 and sync_id=2. sync_pulse is high for 2 cycles, then busy stays high for 8 more cycles, then IDLE.
- Round-robin: req=4'b1111 for 1 cycle → grants in order 0,1,2,3, each 11 edges apart. ack is one-hot each time and no ovf sets.
- Coalesce: req[1] at edges 0 and 1 while another source holds the channel → one grant for source 1 only, and ovf[1]=1. ovf_clr[1] at the same edge as a new coalesce → ovf[1] stays 1.
- Re-request at grant: req[3]=1 on its own grant edge → pend[3] stays set, a second grant follows after the gap, and ovf[3]=0.
- Enable gating: en=0 with pend=4'b0011 → no ack for 20 cycles. Raising en → grant to source 0 on the next edge. Dropping en mid-PULSE → the pulse and gap still complete.
- Async reset: assert rst mid-PULSE, between clock edges → sync_pulse, busy and pend go to 0 without waiting for a clock edge. After release the first grant goes to the lowest pending index.
